jtag_shifter: RTL and testbench

JTAG_SHIFTER -- requirements
Module: jtag_shifter

---
 rtl/jtag_pkg.sv | 17 +
 rtl/jtag_tck_gen.sv | 27 ++
 rtl/jtag_shifter.sv | 178 +++++++++++++++++
 tb/tb_jtag_shifter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared FSM encoding, TRST period count and HALF helper for the JTAG shifter
package jtag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TCKL = 2'd1,
    ST_TCKH = 2'd2,
    ST_TRST = 2'd3
  } jtag_state_e;

  localparam int unsigned TRST_PERIODS = 5;

  function automatic int unsigned half_cycles(input int unsigned ratio);
    return ratio / 2;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - half-TCK-period counter; strobes phase_end on the last CLK of each phase
module jtag_tck_gen #(
  parameter int unsigned C_HALF = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic phase_end
);

  localparam int unsigned CNT_W = (C_HALF > 1) ? $clog2(C_HALF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(C_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_end = run && (cnt_q == LAST);
    cnt_d     = cnt_q + 1'b1;
    if (!run || phase_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jtag_shifter.sv
// rtl/jtag_shifter.sv - JTAG vector shifter: LSB-first TMS/TDI scan with TDO capture
// Optional TRST sequencer enabled by defining JTAG_SHIFTER_TRST_EN.
module jtag_shifter
  import jtag_pkg::*;
#(
  parameter int C_VEC_WIDTH       = 32,
  parameter int C_TCK_CLOCK_RATIO = 8,
  parameter int C_LEN_WIDTH       = 7
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [C_LEN_WIDTH-1:0] LENGTH,
  input  logic [C_VEC_WIDTH-1:0] TMS_VECTOR,
  input  logic [C_VEC_WIDTH-1:0] TDI_VECTOR,
  output logic [C_VEC_WIDTH-1:0] TDO_VECTOR,
  output logic                   BUSY,
  output logic                   DONE,
`ifdef JTAG_SHIFTER_TRST_EN
  input  logic                   TRST_REQ,
  output logic                   TRSTN,
`endif
  output logic                   TCK,
  output logic                   TMS,
  output logic                   TDI,
  input  logic                   TDO
);

  localparam int unsigned HALF = half_cycles(C_TCK_CLOCK_RATIO);
  localparam logic [C_LEN_WIDTH-1:0] MAX_LEN = C_LEN_WIDTH'(C_VEC_WIDTH);

  jtag_state_e            state_q, state_d;
  logic [C_VEC_WIDTH-1:0] tms_sr_q, tms_sr_d, tdi_sr_q, tdi_sr_d, tdo_vec_q, tdo_vec_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d, bit_cnt_q, bit_cnt_d, len_clamped;
  logic                   tms_q, tms_d, tdi_q, tdi_d, done_q, done_d;
  logic                   phase_end;
`ifdef JTAG_SHIFTER_TRST_EN
  localparam logic [3:0] TRST_LAST = 4'(2 * TRST_PERIODS - 1);
  logic [3:0] trst_ph_q, trst_ph_d;
`endif

  jtag_tck_gen #(.C_HALF(HALF)) u_tck_gen (
    .clk       (CLK),
    .resetn    (RESETN),
    .run       (state_q != ST_IDLE),
    .phase_end (phase_end)
  );

  assign len_clamped = (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;

  always_comb begin
    state_d   = state_q;
    tms_sr_d  = tms_sr_q;
    tdi_sr_d  = tdi_sr_q;
    tdo_vec_d = tdo_vec_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    done_d    = 1'b0;
`ifdef JTAG_SHIFTER_TRST_EN
    trst_ph_d = trst_ph_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_TCKL;
            len_d     = len_clamped;
            bit_cnt_d = '0;
            tdo_vec_d = '0;
            tms_d     = TMS_VECTOR[0];
            tdi_d     = TDI_VECTOR[0];
            tms_sr_d  = TMS_VECTOR >> 1;
            tdi_sr_d  = TDI_VECTOR >> 1;
          end
        end
`ifdef JTAG_SHIFTER_TRST_EN
        else if (TRST_REQ) begin
          state_d   = ST_TRST;
          trst_ph_d = '0;
        end
`endif
      end
      ST_TCKL: begin
        // TDO is captured on the same CLK edge that raises TCK
        if (phase_end) begin
          state_d   = ST_TCKH;
          tdo_vec_d = tdo_vec_q | ({{(C_VEC_WIDTH-1){1'b0}}, TDO} << bit_cnt_q);
        end
      end
      ST_TCKH: begin
        if (phase_end) begin
          if ((bit_cnt_q + 1'b1) < len_q) begin
            state_d   = ST_TCKL;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tms_d     = tms_sr_q[0];
            tdi_d     = tdi_sr_q[0];
            tms_sr_d  = tms_sr_q >> 1;
            tdi_sr_d  = tdi_sr_q >> 1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
          end
        end
      end
`ifdef JTAG_SHIFTER_TRST_EN
      ST_TRST: begin
        if (phase_end) begin
          if (trst_ph_q == TRST_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            trst_ph_d = trst_ph_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // abort wins over a completion landing in the same cycle
    if (ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      tms_d   = 1'b0;
      tdi_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      tms_sr_q  <= '0;
      tdi_sr_q  <= '0;
      tdo_vec_q <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef JTAG_SHIFTER_TRST_EN
      trst_ph_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tms_sr_q  <= tms_sr_d;
      tdi_sr_q  <= tdi_sr_d;
      tdo_vec_q <= tdo_vec_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      done_q    <= done_d;
`ifdef JTAG_SHIFTER_TRST_EN
      trst_ph_q <= trst_ph_d;
`endif
    end
  end

  assign TDO_VECTOR = tdo_vec_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = done_q;
  assign TDI        = tdi_q;
`ifdef JTAG_SHIFTER_TRST_EN
  assign TCK   = (state_q == ST_TCKH) || ((state_q == ST_TRST) && trst_ph_q[0]);
  assign TMS   = tms_q || (state_q == ST_TRST);
  assign TRSTN = !((state_q == ST_TRST) && RESETN);
`else
  assign TCK   = (state_q == ST_TCKH);
  assign TMS   = tms_q;
`endif

endmodule

// File: tb/tb_jtag_shifter.sv
// tb/tb_jtag_shifter.sv - table-driven scoreboard bench for jtag_shifter
module tb_jtag_shifter;

  logic        clk = 1'b0;
  logic        resetn, start, abort_i, tdo;
  logic [6:0]  length;
  logic [31:0] tms_vec, tdi_vec, tdo_vec;
  logic        busy, done, tck, tms, tdi;
  logic        start2, tdo2;
  logic [3:0]  length2;
  logic [7:0]  tdo_vec2;
  logic        busy2, done2, tck2, tms2, tdi2;
`ifdef JTAG_SHIFTER_TRST_EN
  logic        trst_req, trstn, trstn2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_shifter #(.C_VEC_WIDTH(32), .C_TCK_CLOCK_RATIO(8), .C_LEN_WIDTH(7)) dut (
    .CLK(clk), .RESETN(resetn), .START(start), .ABORT(abort_i), .LENGTH(length),
    .TMS_VECTOR(tms_vec), .TDI_VECTOR(tdi_vec), .TDO_VECTOR(tdo_vec),
    .BUSY(busy), .DONE(done),
`ifdef JTAG_SHIFTER_TRST_EN
    .TRST_REQ(trst_req), .TRSTN(trstn),
`endif
    .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo)
  );

  jtag_shifter #(.C_VEC_WIDTH(8), .C_TCK_CLOCK_RATIO(2), .C_LEN_WIDTH(4)) dut2 (
    .CLK(clk), .RESETN(resetn), .START(start2), .ABORT(1'b0), .LENGTH(length2),
    .TMS_VECTOR(8'h05), .TDI_VECTOR(8'h02), .TDO_VECTOR(tdo_vec2),
    .BUSY(busy2), .DONE(done2),
`ifdef JTAG_SHIFTER_TRST_EN
    .TRST_REQ(1'b0), .TRSTN(trstn2),
`endif
    .TCK(tck2), .TMS(tms2), .TDI(tdi2), .TDO(tdo2)
  );

  typedef struct {
    logic [6:0]  len;
    logic [31:0] tms, tdi, pat, exp_tdo;
    int          exp_pulses, exp_lat;
    bit          repulse;
  } vec_t;

  typedef struct {
    logic [31:0] tdo, tms_bits, tdi_bits;
    int          pulses, lat;
  } exp_t;

  vec_t tbl[7];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] lenmask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << n) - 32'd1;
  endfunction

  task automatic run_scan(input vec_t v, input string tag);
    exp_t        e, got;
    int          n, rises;
    logic [4:0]  ri;
    logic [31:0] otms, otdi, pat;
    logic        prev_tck, seen, busy_at_done;
    e.tdo      = v.exp_tdo;
    e.pulses   = v.exp_pulses;
    e.lat      = v.exp_lat;
    e.tms_bits = v.tms & lenmask(v.exp_pulses);
    e.tdi_bits = v.tdi & lenmask(v.exp_pulses);
    sb.push_back(e);
    @(posedge clk); #1;
    length = v.len; tms_vec = v.tms; tdi_vec = v.tdi; pat = v.pat;
    tdo = pat[0]; start = 1'b1;
    n = 0; rises = 0; otms = '0; otdi = '0; prev_tck = 1'b0; seen = 1'b0; busy_at_done = 1'b1;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (v.repulse && n == 20) begin start = 1'b1; length = 7'd3; end
      if (v.repulse && n == 21) start = 1'b0;
      if (tck && !prev_tck) begin
        if (rises < 32) begin
          ri = rises[4:0];
          otms[ri] = tms;
          otdi[ri] = tdi;
        end
        rises++;
        if (rises < 32) begin
          ri = rises[4:0];
          tdo = pat[ri];
        end
      end
      prev_tck = tck;
      if (done) begin seen = 1'b1; busy_at_done = busy; end
    end
    got = sb.pop_front();
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(got.lat));
    check({tag, "_tck_pulses"}, 64'(rises), 64'(got.pulses));
    check({tag, "_tdo_vector"}, 64'(tdo_vec), 64'(got.tdo));
    check({tag, "_tms_bits"}, 64'(otms), 64'(got.tms_bits));
    check({tag, "_tdi_bits"}, 64'(otdi), 64'(got.tdi_bits));
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
  endtask

  task automatic start_raw(input logic [6:0] len);
    @(posedge clk); #1;
    length = len; tms_vec = 32'hFFFF_FFFF; tdi_vec = 32'hFFFF_FFFF; tdo = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_rises(input int k, input string tag);
    int  r, n;
    logic prev;
    r = 0; n = 0; prev = tck;
    while (r < k && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (tck && !prev) r++;
      prev = tck;
    end
    if (r < k) check({tag, "_wait_timeout"}, 64'(r), 64'(k));
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int cnt, n, rises;
    logic prev;
    tbl[0] = '{7'd5,  32'h0000_001F, 32'h0000_000A, 32'hFFFF_FFFF, 32'h0000_001F, 5,  41,  1'b0};
    tbl[1] = '{7'd8,  32'h0000_0000, 32'h0000_00FF, 32'h0000_00A5, 32'h0000_00A5, 8,  65,  1'b1};
    tbl[2] = '{7'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00A5, 0,  1,   1'b0};
    tbl[3] = '{7'd40, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_0000, 32'hFFFF_0000, 32, 257, 1'b0};
    tbl[4] = '{7'd1,  32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1,  9,   1'b0};
    tbl[5] = '{7'd32, 32'h8000_0001, 32'h55AA_55AA, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32, 257, 1'b0};
    tbl[6] = '{7'd3,  32'h0000_0006, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0007, 3,  25,  1'b0};

    resetn = 1'b0; start = 1'b0; abort_i = 1'b0; tdo = 1'b0; length = '0;
    tms_vec = '0; tdi_vec = '0; start2 = 1'b0; tdo2 = 1'b1; length2 = '0;
`ifdef JTAG_SHIFTER_TRST_EN
    trst_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins", 64'({tck, tms, tdi, busy, done}), 64'd0);
    check("reset_tdo_vector", 64'(tdo_vec), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) run_scan(tbl[i], $sformatf("vec%0d", i));

    // abort on the third TCK high phase, then a clean scan
    start_raw(7'd10);
    wait_rises(3, "abort");
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_pins", 64'({tck, tms, tdi, busy, done}), 64'd0);
    count_done(30, cnt);
    check("abort_no_done", 64'(cnt), 64'd0);
    run_scan('{7'd4, 32'h0000_0009, 32'h0000_0006, 32'h0000_0003, 32'h0000_0003, 4, 33, 1'b0}, "post_abort");

    // reset mid-scan with START held
    start_raw(7'd10);
    repeat (30) @(posedge clk);
    #1;
    resetn = 1'b0; start = 1'b1; length = 7'd5;
    @(posedge clk); #1;
    check("rst_mid_pins", 64'({tck, tms, tdi, busy, done}), 64'd0);
    check("rst_mid_tdo_vector", 64'(tdo_vec), 64'd0);
    @(posedge clk); #1;
    check("rst_start_ignored", 64'(busy), 64'd0);
    start = 1'b0; resetn = 1'b1;
    count_done(20, cnt);
    check("rst_no_done", 64'(cnt), 64'd0);

    // ratio 2 instance
    @(posedge clk); #1;
    length2 = 4'd3; start2 = 1'b1;
    n = 0; rises = 0; prev = 1'b0;
    while (!done2 && n < 50) begin
      @(posedge clk); #1;
      n++;
      start2 = 1'b0;
      if (tck2 && !prev) rises++;
      prev = tck2;
    end
    check("r2_latency", 64'(n), 64'd7);
    check("r2_pulses", 64'(rises), 64'd3);
    check("r2_tdo_vector", 64'(tdo_vec2), 64'h07);

`ifdef JTAG_SHIFTER_TRST_EN
    begin
      int low, tms_bad;
      @(posedge clk); #1;
      check("trstn_idle", 64'(trstn), 64'd1);
      trst_req = 1'b1;
      n = 0; low = 0; tms_bad = 0;
      while (!done && n < 100) begin
        @(posedge clk); #1;
        n++;
        trst_req = 1'b0;
        if (!trstn) begin
          low++;
          if (!tms) tms_bad++;
        end
      end
      check("trst_low_cycles", 64'(low), 64'd40);
      check("trst_tms_high", 64'(tms_bad), 64'd0);
      check("trst_done_latency", 64'(n), 64'd41);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
